// File: rtl/memorio_pkg.sv
// Shared definitions for the memory-stage responder: width encodings, FSM states and
// the IO address-region pattern used by the controller.
package memorio_pkg;

  // Access width encodings; 2'b10 is reserved and rejected as a request error.
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_RSVD = 2'b10;
  localparam logic [1:0] W_WORD = 2'b11;

  // Upper 22 address bits the controller decodes as the IO region.
  localparam logic [21:0] IO_REGION_HIGH = 22'h3FFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StRamIssue,
    StRamWait,
    StIoAccess,
    StDone
  } state_e;

  // Half accesses need an even address, word accesses a 4-byte aligned one.
  function automatic logic f_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    return ((width == W_HALF) && addr_lo[0]) || ((width == W_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/memorio_lane.sv
// Little-endian lane steering shared by the BRAM and IO paths: byte-enable mask,
// lane-replicated store data and aligned, sign/zero-extended load data.
module memorio_lane
  import memorio_pkg::*;
(
  input  logic [1:0]  i_width,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_sign,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_mask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and half-word out of the raw read word.
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Decode width into mask, replicated store data and extended load data.
  always_comb begin
    o_mask  = 4'b0000;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_width)
      W_BYTE: begin
        o_mask  = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_sign & w_byte[7]}}, w_byte};
      end
      W_HALF: begin
        o_mask  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_sign & w_half[15]}}, w_half};
      end
      W_WORD: begin
        o_mask  = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
      default: begin
        o_mask  = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/memorio_access.sv
// Data-side responder for the controller's memory stage. Accepts one load/store per start
// pulse, drives the data BRAM or the IO bus and returns aligned load data with a done pulse.
// Optional IO abort on a stuck io_ready is enabled by defining MEMIO_TIMEOUT_EN.
module memorio_access
  import memorio_pkg::*;
#(
  parameter int unsigned RAM_AW     = 14,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_io_read,
  input  logic              i_io_write,
  input  logic [1:0]        i_width,
  input  logic              i_sign,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_addr_err,
  output logic              o_io_timeout,
  output logic              o_ram_en,
  output logic [3:0]        o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata,
  output logic [9:0]        o_io_addr,
  output logic              o_io_rd,
  output logic              o_io_wr,
  output logic [3:0]        o_io_be,
  output logic [31:0]       o_io_wdata,
  input  logic [31:0]       i_io_rdata,
  input  logic              i_io_ready
);

  state_e      r_state;
  state_e      w_state_next;
  logic        r_load;
  logic        r_store;
  logic [1:0]  r_width;
  logic        r_sign;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [3:0]  w_strobes;
  logic        w_req;
  logic        w_bad;
  logic        w_to_ram;
  logic [31:0] w_raw;
  logic [3:0]  w_mask;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_lane_rdata;
  logic        w_limit;
  logic        w_unused;

  assign w_strobes = {i_mem_read, i_mem_write, i_io_read, i_io_write};
  // A start with no strobe at all is not a request.
  assign w_req     = (r_state == StIdle) && i_start && (w_strobes != 4'b0000);
  assign w_bad     = ($countones(w_strobes) > 1) || (i_width == W_RSVD) ||
                     f_misaligned(i_width, i_addr[1:0]);
  assign w_to_ram  = i_mem_read | i_mem_write;
  assign w_raw     = (r_state == StIoAccess) ? i_io_rdata : i_ram_rdata;

  // Address bits above the BRAM/IO windows and the timeout limit may go unused.
  assign w_unused  = ^{r_addr, IO_TIMEOUT};

  memorio_lane u_lane (
    .i_width   (r_width),
    .i_addr_lo (r_addr[1:0]),
    .i_sign    (r_sign),
    .i_wdata   (r_wdata),
    .i_rdata   (w_raw),
    .o_mask    (w_mask),
    .o_wdata   (w_lane_wdata),
    .o_rdata   (w_lane_rdata)
  );

`ifdef MEMIO_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(IO_TIMEOUT + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_tmo;

  // Limit hit on the last allowed cycle without io_ready; io_ready in that cycle wins.
  assign w_limit = (r_state == StIoAccess) && !i_io_ready &&
                   (r_cnt == CntW'(IO_TIMEOUT - 1));

  // Wait counter: cleared outside IO_ACCESS, counts cycles without io_ready inside it.
  always_ff @(posedge i_clock) begin
    if (i_reset || (r_state != StIoAccess)) begin
      r_cnt <= '0;
    end else if (!i_io_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Abort flag, set on timeout and cleared by each accepted request.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tmo <= 1'b0;
    end else if (w_req) begin
      r_tmo <= 1'b0;
    end else if (w_limit) begin
      r_tmo <= 1'b1;
    end
  end

  assign o_io_timeout = (r_state == StDone) && r_tmo;
`else
  assign w_limit      = 1'b0;
  assign o_io_timeout = 1'b0;
`endif

  // State register plus request latch and load-result capture.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_load  <= 1'b0;
      r_store <= 1'b0;
      r_width <= 2'b00;
      r_sign  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_req) begin
        r_load  <= i_mem_read | i_io_read;
        r_store <= i_mem_write | i_io_write;
        r_width <= i_width;
        r_sign  <= i_sign;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_err   <= w_bad;
      end
      if (r_state == StRamWait) begin
        r_rdata <= w_lane_rdata;
      end else if ((r_state == StIoAccess) && i_io_ready && r_load) begin
        r_rdata <= w_lane_rdata;
      end else if (w_limit) begin
        r_rdata <= '0;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_req) begin
          if (w_bad) begin
            w_state_next = StDone;
          end else if (w_to_ram) begin
            w_state_next = StRamIssue;
          end else begin
            w_state_next = StIoAccess;
          end
        end
      end
      StRamIssue: w_state_next = r_load ? StRamWait : StDone;
      StRamWait:  w_state_next = StDone;
      StIoAccess: begin
        if (i_io_ready || w_limit) begin
          w_state_next = StDone;
        end
      end
      StDone:     w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // Bus strobes and status outputs decoded from the current state.
  always_comb begin
    o_done      = (r_state == StDone);
    o_busy      = (r_state != StIdle);
    o_addr_err  = (r_state == StDone) && r_err;
    o_ram_en    = (r_state == StRamIssue);
    o_ram_we    = ((r_state == StRamIssue) && r_store) ? w_mask : 4'b0000;
    o_io_rd     = (r_state == StIoAccess) && r_load;
    o_io_wr     = (r_state == StIoAccess) && r_store;
    o_io_be     = (r_state == StIoAccess) ? w_mask : 4'b0000;
    o_rdata     = r_rdata;
    o_ram_addr  = r_addr[RAM_AW+1:2];
    o_ram_wdata = w_lane_wdata;
    o_io_addr   = r_addr[9:0];
    o_io_wdata  = w_lane_wdata;
  end

endmodule

// File: tb/tb_memorio_access.sv
// Scoreboard bench for memorio_access: stimulus pushes the expected done cycle and
// result, a negedge monitor pops and compares whenever done is presented.
module tb_memorio_access;

  localparam int unsigned RamAw     = 14;
  localparam int unsigned IoTimeout = 8;

  logic             clk = 1'b0;
  logic             reset, start, mem_read, mem_write, io_read, io_write, sign, io_ready;
  logic [1:0]       width;
  logic [31:0]      addr, wdata, io_rdata;
  logic [31:0]      ram_rdata = '0;
  logic [31:0]      rdata, ram_wdata, io_wdata;
  logic             done, busy, addr_err, io_timeout, ram_en, io_rd, io_wr;
  logic [3:0]       ram_we, io_be;
  logic [RamAw-1:0] ram_addr;
  logic [9:0]       io_addr;

  always #5 clk = ~clk;

  memorio_access #(
    .RAM_AW     (RamAw),
    .IO_TIMEOUT (IoTimeout)
  ) dut (
    .i_clock      (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_mem_read   (mem_read),
    .i_mem_write  (mem_write),
    .i_io_read    (io_read),
    .i_io_write   (io_write),
    .i_width      (width),
    .i_sign       (sign),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_rdata      (rdata),
    .o_done       (done),
    .o_busy       (busy),
    .o_addr_err   (addr_err),
    .o_io_timeout (io_timeout),
    .o_ram_en     (ram_en),
    .o_ram_we     (ram_we),
    .o_ram_addr   (ram_addr),
    .o_ram_wdata  (ram_wdata),
    .i_ram_rdata  (ram_rdata),
    .o_io_addr    (io_addr),
    .o_io_rd      (io_rd),
    .o_io_wr      (io_wr),
    .o_io_be      (io_be),
    .o_io_wdata   (io_wdata),
    .i_io_rdata   (io_rdata),
    .i_io_ready   (io_ready)
  );

  typedef struct {
    string       tag;
    int unsigned cyc;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] mem_word = 32'h80FF7F01;
  logic [31:0] exp_rdata = '0;

  // Cycle counter and a one-cycle-latency BRAM returning a fixed word.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) ram_rdata <= mem_word;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest expected completion.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no completion", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.tag, "_done_cycle"}, cyc, mon_e.cyc);
        check({mon_e.tag, "_rdata"}, rdata, mon_e.rdata);
        check({mon_e.tag, "_addr_err"}, {31'b0, addr_err}, {31'b0, mon_e.err});
        check({mon_e.tag, "_io_timeout"}, {31'b0, io_timeout}, {31'b0, mon_e.tmo});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns one cycle after acceptance.
  task automatic issue(input logic [3:0] strb, input logic [1:0] w, input logic s,
                       input logic [31:0] a, input logic [31:0] d);
    {mem_read, mem_write, io_read, io_write} = strb;
    width = w; sign = s; addr = a; wdata = d; start = 1'b1;
    tick();
    start = 1'b0;
    {mem_read, mem_write, io_read, io_write} = 4'b0000;
  endtask

  task automatic expect_done(input string tag, input int unsigned lat, input logic [31:0] rd,
                             input logic err, input logic tmo);
    exp_t e;
    e.tag = tag; e.cyc = cyc + lat; e.rdata = rd; e.err = err; e.tmo = tmo;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 50 && busy; i++) tick();
    check({tag, "_returns_idle"}, {31'b0, busy}, 32'd0);
  endtask

  typedef struct {
    string tag; logic [1:0] w; logic [31:0] a; logic [31:0] d; logic [3:0] we; logic [31:0] rep;
  } st_vec_t;
  typedef struct {
    string tag; logic [1:0] w; logic s; logic [31:0] a; logic [31:0] exp;
  } ld_vec_t;
  typedef struct {
    string tag; logic [3:0] strb; logic [1:0] w; logic [31:0] a;
  } er_vec_t;

  st_vec_t st_v[5];
  ld_vec_t ld_v[7];
  er_vec_t er_v[5];

  initial begin
    int unsigned n_strobe;

    st_v[0] = '{"st_byte3", 2'b00, 32'h00000013, 32'h000000AB, 4'b1000, 32'hABABABAB};
    st_v[1] = '{"st_half_hi", 2'b01, 32'h00000002, 32'h00001234, 4'b1100, 32'h12341234};
    st_v[2] = '{"st_half_lo", 2'b01, 32'h00000100, 32'h0000BEEF, 4'b0011, 32'hBEEFBEEF};
    st_v[3] = '{"st_word", 2'b11, 32'h00000008, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF};
    st_v[4] = '{"st_byte1", 2'b00, 32'h00000005, 32'h123456FF, 4'b0010, 32'hFFFFFFFF};

    ld_v[0] = '{"ld_byte2_s", 2'b00, 1'b1, 32'h00000002, 32'hFFFFFFFF};
    ld_v[1] = '{"ld_byte2_u", 2'b00, 1'b0, 32'h00000002, 32'h000000FF};
    ld_v[2] = '{"ld_byte0_s", 2'b00, 1'b1, 32'h00000000, 32'h00000001};
    ld_v[3] = '{"ld_byte3_s", 2'b00, 1'b1, 32'h00000003, 32'hFFFFFF80};
    ld_v[4] = '{"ld_half_hi_s", 2'b01, 1'b1, 32'h00000002, 32'hFFFF80FF};
    ld_v[5] = '{"ld_half_lo_u", 2'b01, 1'b0, 32'h00000000, 32'h00007F01};
    ld_v[6] = '{"ld_word", 2'b11, 1'b1, 32'h00000004, 32'h80FF7F01};

    er_v[0] = '{"err_word_mis", 4'b1000, 2'b11, 32'h00000006};
    er_v[1] = '{"err_half_mis", 4'b0100, 2'b01, 32'h00000001};
    er_v[2] = '{"err_rsvd_w", 4'b1000, 2'b10, 32'h00000000};
    er_v[3] = '{"err_multi", 4'b1010, 2'b11, 32'h00000000};
    er_v[4] = '{"err_io_mis", 4'b0001, 2'b11, 32'hFFFFFC42};

    reset = 1'b1; start = 1'b0; {mem_read, mem_write, io_read, io_write} = 4'b0000;
    width = 2'b00; sign = 1'b0; addr = '0; wdata = '0; io_rdata = '0; io_ready = 1'b0;
    repeat (2) tick();

    // Reset state.
    @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_done_busy", {30'b0, done, busy}, 32'd0);
    check("rst_ram", {27'b0, ram_en, ram_we}, 32'd0);
    check("rst_io", {30'b0, io_rd, io_wr}, 32'd0);
    check("rst_status", {30'b0, addr_err, io_timeout}, 32'd0);
    tick();
    reset = 1'b0;

    // BRAM stores: done at T+2, rdata held.
    foreach (st_v[i]) begin
      expect_done(st_v[i].tag, 2, exp_rdata, 1'b0, 1'b0);
      issue(4'b0100, st_v[i].w, 1'b0, st_v[i].a, st_v[i].d);
      @(negedge clk);
      check({st_v[i].tag, "_ram_en"}, {31'b0, ram_en}, 32'd1);
      check({st_v[i].tag, "_ram_we"}, {28'b0, ram_we}, {28'b0, st_v[i].we});
      check({st_v[i].tag, "_ram_wdata"}, ram_wdata, st_v[i].rep);
      check({st_v[i].tag, "_ram_addr"}, {18'b0, ram_addr}, st_v[i].a >> 2);
      wait_idle(st_v[i].tag);
    end

    // BRAM loads: done at T+3.
    foreach (ld_v[i]) begin
      expect_done(ld_v[i].tag, 3, ld_v[i].exp, 1'b0, 1'b0);
      exp_rdata = ld_v[i].exp;
      issue(4'b1000, ld_v[i].w, ld_v[i].s, ld_v[i].a, 32'h0);
      @(negedge clk);
      check({ld_v[i].tag, "_ram_en_we"}, {27'b0, ram_en, ram_we}, 32'h10);
      wait_idle(ld_v[i].tag);
    end

    // Request errors: done at T+1 with addr_err, no access strobes.
    foreach (er_v[i]) begin
      expect_done(er_v[i].tag, 1, exp_rdata, 1'b1, 1'b0);
      issue(er_v[i].strb, er_v[i].w, 1'b0, er_v[i].a, 32'h0);
      @(negedge clk);
      check({er_v[i].tag, "_no_access"}, {29'b0, ram_en, io_rd, io_wr}, 32'd0);
      wait_idle(er_v[i].tag);
    end

    // Start without any strobe is ignored.
    issue(4'b0000, 2'b11, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("nostrobe_ignored", {30'b0, busy, done}, 32'd0);
    tick();

    // IO word read, io_ready on the 4th IO_ACCESS cycle: done at T+5.
    expect_done("io_rd_word", 5, 32'h00001234, 1'b0, 1'b0);
    exp_rdata = 32'h00001234;
    issue(4'b0010, 2'b11, 1'b0, 32'hFFFFFC40, 32'h0);
    n_strobe = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin io_ready = 1'b1; io_rdata = 32'h00001234; end
      @(negedge clk);
      if (io_rd && io_addr == 10'h040 && io_be == 4'b1111) n_strobe++;
      tick();
    end
    io_ready = 1'b0; io_rdata = '0;
    check("io_rd_strobe_cycles", n_strobe, 32'd4);
    @(negedge clk);
    check("io_rd_dropped", {31'b0, io_rd}, 32'd0);
    wait_idle("io_rd_word");

    // IO signed byte read, immediate ready: done at T+2.
    expect_done("io_rd_byte", 2, 32'hFFFFFF80, 1'b0, 1'b0);
    exp_rdata = 32'hFFFFFF80;
    issue(4'b0010, 2'b00, 1'b1, 32'hFFFFFC41, 32'h0);
    io_ready = 1'b1; io_rdata = 32'h00008000;
    @(negedge clk);
    check("io_rd_byte_be", {28'b0, io_be}, 32'h2);
    tick();
    io_ready = 1'b0;
    wait_idle("io_rd_byte");

    // IO half write, immediate ready.
    expect_done("io_wr_half", 2, exp_rdata, 1'b0, 1'b0);
    issue(4'b0001, 2'b01, 1'b0, 32'hFFFFFC46, 32'h0000CAFE);
    io_ready = 1'b1;
    @(negedge clk);
    check("io_wr_half_strobe", {20'b0, io_wr, io_rd, io_addr}, {20'b0, 2'b10, 10'h046});
    check("io_wr_half_be", {28'b0, io_be}, 32'hC);
    check("io_wr_half_wdata", io_wdata, 32'hCAFECAFE);
    tick();
    io_ready = 1'b0;
    wait_idle("io_wr_half");

    // Reset during RAM_WAIT drops the access; the next start works normally.
    issue(4'b1000, 2'b11, 1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_rdata = '0;
    @(negedge clk);
    check("rst_wait_idle", {30'b0, busy, done}, 32'd0);
    check("rst_wait_rdata", rdata, 32'd0);
    tick();
    expect_done("post_rst_ld", 3, 32'h80FF7F01, 1'b0, 1'b0);
    exp_rdata = 32'h80FF7F01;
    issue(4'b1000, 2'b11, 1'b0, 32'h0, 32'h0);
    wait_idle("post_rst_ld");

`ifdef MEMIO_TIMEOUT_EN
    // io_ready arriving on the limit cycle completes normally.
    expect_done("io_ready_at_limit", IoTimeout + 1, 32'h00005A5A, 1'b0, 1'b0);
    exp_rdata = 32'h00005A5A;
    issue(4'b0010, 2'b11, 1'b0, 32'hFFFFFC80, 32'h0);
    repeat (IoTimeout - 1) tick();
    io_ready = 1'b1; io_rdata = 32'h00005A5A;
    tick();
    io_ready = 1'b0;
    wait_idle("io_ready_at_limit");

    // Stuck io_ready: io_wr for IoTimeout cycles, then done with io_timeout and rdata 0.
    expect_done("io_timeout", IoTimeout + 1, 32'h0, 1'b0, 1'b1);
    exp_rdata = '0;
    issue(4'b0001, 2'b11, 1'b0, 32'hFFFFFC80, 32'h55);
    n_strobe = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (io_wr) n_strobe++;
      tick();
    end
    check("io_timeout_wr_cycles", n_strobe, IoTimeout);
    wait_idle("io_timeout");
`else
    // Without the timeout IO_ACCESS waits indefinitely; recover with reset.
    issue(4'b0001, 2'b11, 1'b0, 32'hFFFFFC80, 32'h55);
    n_strobe = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (io_wr) n_strobe++;
      tick();
    end
    check("io_wait_wr_cycles", n_strobe, 32'd20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_rdata = '0;
    @(negedge clk);
    check("io_wait_reset_idle", {30'b0, busy, io_wr}, 32'd0);
    tick();
`endif

    repeat (3) tick();
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memorio_access.md
Name: memorio_access

Overview:
- Data-side responder for the multicycle controller's memory stage.
- Accepts one load/store request per `start` pulse and decodes the width/sign attributes.
- Drives either the data BRAM (byte-enable writes, 1-cycle read latency) or the IO bus (ready handshake).
- Returns aligned, sign/zero-extended load data with a one-cycle `done` pulse. The controller holds its memory state until `done`.

Parameters:
- RAM_AW, 14, word-address width of data BRAM (2^14 words = 64 KB).
- IO_TIMEOUT, 255, max cycles waiting for io_ready before abort (only with MEMIO_TIMEOUT_EN).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request qualifier, sampled only in IDLE
- mem_read  in  1  load from BRAM
- mem_write  in  1  store to BRAM
- io_read  in  1  load from IO region
- io_write  in  1  store to IO region
- width  in  2  00 byte, 01 half, 11 word, 10 reserved
- sign  in  1  1 = sign-extend loads, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- rdata  out  32  load result; held until the next start
- done  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after an accepted start through the done cycle
- addr_err  out  1  valid with done: misaligned, reserved width, or multiple strobes
- io_timeout  out  1  valid with done: IO access aborted
- ram_en  out  1  BRAM enable
- ram_we  out  4  BRAM byte write enables (lane0 = bits 7:0)
- ram_addr  out  RAM_AW  BRAM word address, equals addr[RAM_AW+1:2]
- ram_wdata  out  32  lane-replicated store data
- ram_rdata  in  32  BRAM data, valid the cycle after ram_en
- io_addr  out  10  IO offset, equals addr[9:0]
- io_rd  out  1  IO read strobe
- io_wr  out  1  IO write strobe
- io_be  out  4  IO byte enables
- io_wdata  out  32  lane-replicated store data
- io_rdata  in  32  IO read data, valid when io_ready=1
- io_ready  in  1  IO completion

Behaviour:

Reset:
- State goes to IDLE. Every output is 0, including rdata.
- A request in flight is dropped: no done pulse, strobes deasserted on the next edge.

Request acceptance (cycle T):
- Accepted only in IDLE with start=1; start is ignored at all other times.
- All request inputs are latched at T.
- If no strobe is set, the start is ignored.
- If more than one strobe is set, or width=10, or the address is misaligned (half with addr[0]=1; word with addr[1:0]!=00): no access is made, and done=1 with addr_err=1 at T+1.

FSM states: IDLE, RAM_ISSUE, RAM_WAIT, IO_ACCESS, DONE.
- IDLE → RAM_ISSUE on a valid mem_read or mem_write.
- IDLE → IO_ACCESS on a valid io_read or io_write.
- IDLE → DONE on any request error.
- RAM_ISSUE (T+1): ram_en=1, ram_we=lane mask for stores (0 for loads). Store → DONE; load → RAM_WAIT.
- RAM_WAIT (T+2): ram_rdata is aligned/extended and registered into rdata. Next state DONE.
- Resulting latency: store done at T+2, load done at T+3.
- IO_ACCESS: io_rd or io_wr held with io_be/io_wdata stable until a cycle with io_ready=1. In that cycle load data is captured and the next state is DONE. Minimum: done at T+2.
- DONE: done=1 for one cycle, then IDLE. addr_err and io_timeout are valid only in the done cycle and otherwise 0.

Lanes (little-endian, k = addr[1:0]):
- Byte: mask = 1<<k; wdata[7:0] replicated into all 4 lanes.
- Half: mask = addr[1] ? 1100 : 0011; wdata[15:0] replicated twice.
- Word: mask = 1111.

Load extraction:
- Byte: selected lane; bit 7 extended if sign=1, else zero-extended.
- Half: selected half; bit 15 extended if sign=1, else zero-extended.
- Word: passed through; sign is ignored.

Optional Feature:
Macro: MEMIO_TIMEOUT_EN
- Defined:
  - A counter clears on entry to IO_ACCESS and increments each cycle without io_ready.
  - When it reaches IO_TIMEOUT, strobes drop, the next state is DONE with io_timeout=1, and rdata becomes 0.
  - io_ready arriving in the same cycle as the limit wins: normal completion, io_timeout=0.
- Undefined: IO_ACCESS waits indefinitely, io_timeout is tied to 0, and no counter exists.

Decomposition:
- Shared package memorio_pkg holds:
  - width encodings W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b11;
  - the FSM state enum;
  - IO_REGION_HIGH=22'h3FFFFF, the address-high pattern the controller uses for IO.
- Sub-module memorio_lane is combinational. From width, addr[1:0] and sign it produces the byte mask, the replicated write data, and the extracted/extended load data. It is shared by the BRAM and IO paths.

Test Plan:
1. Store byte: addr=0x00000013, width=00, wdata=0x000000AB → ram_we=1000, ram_wdata=0xABABABAB at T+1; done at T+2.
2. Signed/unsigned byte load: ram_rdata=0x80FF7F01.
   - addr=0x00000002, sign=1 → rdata=0xFFFFFFFF at done (T+3).
   - Same access with sign=0 → rdata=0x000000FF.
3. Misaligned: word load at 0x00000006 → done at T+1 with addr_err=1; ram_en and io_rd never asserted.
4. IO read: addr=0xFFFFFC40, io_ready asserted on the 4th cycle of IO_ACCESS with io_rdata=0x1234 → io_addr=0x040 held 4 cycles; rdata=0x00001234, done the next cycle.
5. Timeout (MEMIO_TIMEOUT_EN, IO_TIMEOUT=8): io_write with io_ready held 0 → io_wr high 8 cycles, then done with io_timeout=1. Without the macro: io_wr stays high, no done.
6. Reset while in RAM_WAIT → next cycle IDLE, rdata=0, no done; a new start on the following cycle is accepted normally.
